// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event pulses into fixed-length LED-visible pulses.
// Events arriving during a pulse are queued and replayed after a low gap.
`timescale 1ns/1ps

module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int MAX_PEND    = 7,
  parameter int PEND_W      = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              stretch_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_LEN = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                stretch_q;
  logic                ovf_q, ovf_d;
  logic                pulse_in_q;

  logic evt, cnt_zero, gap_done, dequeue, consume, enqueue;

  // A level held high for many cycles counts once: only the rising edge is an event.
  assign evt      = pulse_in & ~pulse_in_q;
  assign cnt_zero = (cnt_q == '0);
  assign gap_done = (state_q == GAP) && cnt_zero;
  assign dequeue  = gap_done && (pend_q != '0);
  assign consume  = gap_done && (pend_q == '0) && evt;
  assign enqueue  = evt && (state_q != IDLE) && !consume;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (enqueue && dequeue) begin
      pend_d = pend_q;
    end else if (dequeue) begin
      pend_d = pend_q - PEND_W'(1);
    end else if (enqueue) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + PEND_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      stretch_q  <= 1'b0;
      ovf_q      <= 1'b0;
      pulse_in_q <= 1'b0;
    end else begin
      pulse_in_q <= pulse_in;
      if (clear) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        pend_q    <= '0;
        stretch_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        pend_q <= pend_d;
        ovf_q  <= ovf_d;
        unique case (state_q)
          IDLE: begin
            if (evt) begin
              state_q   <= HOLD;
              cnt_q     <= HOLD_LOAD;
              stretch_q <= 1'b1;
            end
          end
          HOLD: begin
            if (cnt_zero) begin
              state_q   <= GAP;
              cnt_q     <= GAP_LOAD;
              stretch_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          GAP: begin
            if (cnt_zero) begin
              if (dequeue || consume) begin
                state_q   <= HOLD;
                cnt_q     <= HOLD_LOAD;
                stretch_q <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stretch_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign stretch_out = stretch_q;
  assign busy        = (state_q != IDLE);
  assign pending     = pend_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: stimulus queues expected pulses and
// overflow strobes, a negedge monitor measures each output pulse and compares.
`timescale 1ns/1ps

module tb_pulse_stretcher;

  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int PER  = HOLD + GAP;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       pulse_in;
  logic       clear;
  logic       stretch_out;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  pulse_stretcher #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .MAX_PEND   (7),
    .PEND_W     (3)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pulse_in   (pulse_in),
    .clear      (clear),
    .stretch_out(stretch_out),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int start;
    int len;
  } exp_pulse_t;

  exp_pulse_t exp_q[$];
  int         ovf_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a pulse starts at the first negedge it is seen high and its length
  // is the number of negedges it stays high.
  logic mon_prev = 1'b0;
  int   mon_start = 0;
  always @(negedge Clk) begin
    exp_pulse_t e;
    int         ov;
    if (stretch_out && !mon_prev) mon_start = cyc;
    if (!stretch_out && mon_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: start %0d len %0d, none expected", mon_start, cyc - mon_start);
      end else begin
        e = exp_q.pop_front();
        check("pulse_start", mon_start, e.start);
        check("pulse_len", cyc - mon_start, e.len);
      end
    end
    mon_prev = stretch_out;
    if (overflow) begin
      if (ovf_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_overflow: at cycle %0d, none expected", cyc);
      end else begin
        ov = ovf_q.pop_front();
        check("overflow_cycle", cyc, ov);
      end
    end
  end

  task automatic push_pulse(input int start, input int len);
    exp_pulse_t e;
    e.start = start;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  // Drives pulse_in/clear one bit per cycle (bit i is sampled at edge base+i)
  // and records how long busy was high and the peak pending value.
  task automatic run_pat(input logic [63:0] pat, input logic [63:0] clr, input int ncyc,
                         output int busy_cnt, output int max_pend);
    busy_cnt = 0;
    max_pend = 0;
    for (int i = 0; i < ncyc; i++) begin
      pulse_in = (i < 64) ? pat[i] : 1'b0;
      clear    = (i < 64) ? clr[i] : 1'b0;
      @(negedge Clk);
      if (busy) busy_cnt++;
      if (int'(pending) > max_pend) max_pend = int'(pending);
    end
    pulse_in = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, bcnt, mpend;
    Reset    = 1'b0;
    pulse_in = 1'b0;
    clear    = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_stretch", int'(stretch_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overflow", int'(overflow), 0);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);

    // Single one-cycle pulse.
    base = cyc + 1;
    push_pulse(base, HOLD);
    run_pat(64'h1, 64'h0, 16, bcnt, mpend);
    check("t1_busy_cycles", bcnt, PER);
    check("t1_max_pending", mpend, 0);

    // Three events two cycles apart during the first HOLD.
    base = cyc + 1;
    for (int k = 0; k < 3; k++) push_pulse(base + k * PER, HOLD);
    run_pat(64'h15, 64'h0, 44, bcnt, mpend);
    check("t2_busy_cycles", bcnt, 3 * PER);
    check("t2_max_pending", mpend, 2);

    // Level held high for 20 cycles is a single event.
    base = cyc + 1;
    push_pulse(base, HOLD);
    run_pat(64'hF_FFFF, 64'h0, 30, bcnt, mpend);
    check("t3_busy_cycles", bcnt, PER);
    check("t3_max_pending", mpend, 0);

    // Ten events on alternating cycles: the one at +12 coincides with a dequeue,
    // the queue fills to 7 at +16 and the event at +18 is dropped.
    base = cyc + 1;
    for (int k = 0; k < 9; k++) push_pulse(base + k * PER, HOLD);
    ovf_q.push_back(base + 18);
    run_pat(64'h5_5555, 64'h0, 115, bcnt, mpend);
    check("t4_busy_cycles", bcnt, 9 * PER);
    check("t4_max_pending", mpend, 7);
    check("t4_end_pending", int'(pending), 0);

    // Event on the last GAP cycle with nothing queued: back-to-back, no IDLE.
    base = cyc + 1;
    push_pulse(base, HOLD);
    push_pulse(base + PER, HOLD);
    run_pat(64'h1001, 64'h0, 30, bcnt, mpend);
    check("t5_busy_cycles", bcnt, 2 * PER);
    check("t5_max_pending", mpend, 0);

    // clear mid-HOLD with three events queued.
    base = cyc + 1;
    push_pulse(base, 7);
    run_pat(64'hD5, 64'h80, 20, bcnt, mpend);
    check("t6_busy_cycles", bcnt, 7);
    check("t6_max_pending", mpend, 3);
    check("t6_end_pending", int'(pending), 0);
    check("t6_end_stretch", int'(stretch_out), 0);

    // clear with a coincident event: event discarded, input edge still tracked.
    run_pat(64'h7, 64'h1, 20, bcnt, mpend);
    check("t7_busy_cycles", bcnt, 0);
    check("t7_max_pending", mpend, 0);

    // Reset asserted mid-GAP with one event queued.
    base = cyc + 1;
    push_pulse(base, HOLD);
    run_pat(64'h5, 64'h0, 11, bcnt, mpend);
    check("t8_busy_cycles", bcnt, 11);
    check("t8_pre_pending", int'(pending), 1);
    check("t8_pre_busy", int'(busy), 1);
    #1 Reset = 1'b0;
    #1;
    check("t8_async_stretch", int'(stretch_out), 0);
    check("t8_async_busy", int'(busy), 0);
    check("t8_async_pending", int'(pending), 0);
    check("t8_async_overflow", int'(overflow), 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // Normal operation after reset release.
    base = cyc + 1;
    push_pulse(base, HOLD);
    run_pat(64'h1, 64'h0, 16, bcnt, mpend);
    check("t9_busy_cycles", bcnt, PER);
    check("t9_max_pending", mpend, 0);

    repeat (5) @(negedge Clk);
    check("leftover_pulses", exp_q.size(), 0);
    check("leftover_overflows", ovf_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
